requant: RTL and testbench

REQUANT -- requirements
Module: requant

---
 rtl/requant.sv | 126 ++++++++++++
 tb/tb_requant.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/requant.sv
// Requantizes a 32-bit matmul accumulator to a signed OUT_W-bit activation:
// bias add, Q31 multiply with rounding, rounding right shift, zero-point and clamp.
module requant #(
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [31:0]      in_acc,
  input  logic signed [31:0]      bias,
  input  logic signed [31:0]      mult,
  input  logic        [4:0]       shift,
  input  logic signed [OUT_W-1:0] out_zp,
  input  logic signed [OUT_W-1:0] act_min,
  input  logic signed [OUT_W-1:0] act_max,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data
);

  typedef enum logic [2:0] {sIDLE, sADD, sMUL, sRND, sCLAMP, sOUT} state_t;

  state_t r_state, w_next;

  logic signed [31:0]      r_acc, r_bias, r_mult, r_x, r_h;
  logic        [4:0]       r_shift;
  logic signed [OUT_W-1:0] r_zp, r_min, r_max, r_out;
  logic signed [63:0]      r_p;

  logic signed [32:0]      w_sum;
  logic signed [31:0]      w_x;
  logic signed [63:0]      w_p;
  logic signed [32:0]      w_h33;
  logic signed [31:0]      w_h;
  logic        [32:0]      w_inc;
  logic signed [32:0]      w_rsum, w_r;
  logic signed [33:0]      w_y, w_zp34, w_min34, w_max34, w_lo;
  logic signed [OUT_W-1:0] w_clamp;
  logic                    w_xfer;

  assign w_xfer    = (r_state == sIDLE) && in_valid && !reset;
  assign in_ready  = (r_state == sIDLE) && !reset;
  assign out_valid = (r_state == sOUT);
  assign out_data  = r_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= sIDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      sIDLE:   if (w_xfer) w_next = sADD;
      sADD:    w_next = sMUL;
      sMUL:    w_next = sRND;
      sRND:    w_next = sCLAMP;
      sCLAMP:  w_next = sOUT;
      sOUT:    if (out_ready) w_next = sIDLE;
      default: w_next = sIDLE;
    endcase
  end

  // Saturating 33-bit bias add: overflow shows as disagreeing top two bits.
  assign w_sum = {r_acc[31], r_acc} + {r_bias[31], r_bias};
  always_comb begin
    if (w_sum[32] != w_sum[31]) w_x = w_sum[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
    else                        w_x = w_sum[31:0];
  end

  assign w_p = $signed({{32{r_x[31]}}, r_x}) * $signed({{32{r_mult[31]}}, r_mult});

  // |p| <= 2^62, so the rounded Q31 result needs at most 33 bits.
  assign w_h33 = 33'((r_p + 64'sd1073741824) >>> 31);
  always_comb begin
    if (w_h33[32] != w_h33[31]) w_h = w_h33[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
    else                        w_h = w_h33[31:0];
  end

  // Half-LSB rounding increment, zero when shift is zero.
  assign w_inc   = (33'd1 << r_shift) >> 1;
  assign w_rsum  = $signed({r_h[31], r_h}) + $signed(w_inc);
  assign w_r     = w_rsum >>> r_shift;
  assign w_zp34  = {{(34-OUT_W){r_zp[OUT_W-1]}}, r_zp};
  assign w_min34 = {{(34-OUT_W){r_min[OUT_W-1]}}, r_min};
  assign w_max34 = {{(34-OUT_W){r_max[OUT_W-1]}}, r_max};
  assign w_y     = $signed({w_r[32], w_r}) + w_zp34;

  // Max against act_min first, then min against act_max, so act_max wins on inversion.
  always_comb begin
    w_lo    = (w_y < w_min34) ? w_min34 : w_y;
    w_clamp = (w_lo > w_max34) ? r_max : OUT_W'(w_lo);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_bias  <= '0;
      r_mult  <= '0;
      r_shift <= '0;
      r_zp    <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_x     <= '0;
      r_p     <= '0;
      r_h     <= '0;
      r_out   <= '0;
    end else begin
      if (w_xfer) begin
        r_acc   <= in_acc;
        r_bias  <= bias;
        r_mult  <= mult;
        r_shift <= shift;
        r_zp    <= out_zp;
        r_min   <= act_min;
        r_max   <= act_max;
      end
      if (r_state == sADD)   r_x   <= w_x;
      if (r_state == sMUL)   r_p   <= w_p;
      if (r_state == sRND)   r_h   <= w_h;
      if (r_state == sCLAMP) r_out <= w_clamp;
    end
  end

endmodule

// File: tb/tb_requant.sv
// Directed bench for requant: hand-computed vectors, saturation corners,
// clamp inversion, output back-pressure and mid-flight reset.
module tb_requant;

  logic              clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic signed [31:0] in_acc, bias, mult;
  logic        [4:0]  shift;
  logic signed [7:0]  out_zp, act_min, act_max, out_data;

  int n_vec = 0;
  int n_err = 0;

  requant #(.OUT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .bias(bias), .mult(mult), .shift(shift),
    .out_zp(out_zp), .act_min(act_min), .act_max(act_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    in_acc  = $urandom();
    bias    = $urandom();
    mult    = $urandom();
    shift   = 5'($urandom());
    out_zp  = 8'($urandom());
    act_min = 8'($urandom());
    act_max = 8'($urandom());
  endtask

  // Drive one word, check latency and result; hold=1 leaves the DUT parked in sOUT.
  task automatic run_vec(input string tag, input logic [31:0] a, b, m, input logic [4:0] s,
                         input logic [7:0] zp, mn, mx, input logic [7:0] exp, input bit hold);
    int k;
    @(negedge clk);
    in_acc = a; bias = b; mult = m; shift = s;
    out_zp = zp; act_min = mn; act_max = mx;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_data"}, {24'h0, out_data}, {24'h0, exp});
    if (!hold) begin
      @(posedge clk); #1;
      chk({tag, "_done"}, {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_acc = '0; bias = '0; mult = '0; shift = '0;
    out_zp = '0; act_min = '0; act_max = '0;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {24'h0, out_data}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rst_rel_ready", {31'b0, in_ready}, 32'd1);

    // h=51, r=26, y=21
    run_vec("basic", 32'd101, 32'd0, 32'h40000000, 5'd1, -8'sd5, -8'sd128, 8'sd127, 8'd21, 1'b0);
    // x saturates positive, result clamps high
    run_vec("xsat", 32'h7FFFFFF0, 32'h100, 32'h7FFFFFFF, 5'd0, 8'd0, -8'sd128, 8'sd127, 8'd127, 1'b0);
    // h=-150
    run_vec("lowclamp", -32'sd300, 32'd0, 32'h40000000, 5'd0, 8'd0, -8'sd128, 8'sd127, 8'h80, 1'b0);
    run_vec("zeroclamp", -32'sd300, 32'd0, 32'h40000000, 5'd0, 8'd0, 8'd0, 8'sd127, 8'd0, 1'b0);
    // x=-2^31, mult=-2^31 -> h saturates to 2^31-1, shift 31 rounds to 1
    run_vec("hsat", 32'hC0000000, 32'hC0000000, 32'h80000000, 5'd31, 8'd0, -8'sd128, 8'sd127, 8'd1, 1'b0);
    // inverted clamp bounds: act_max wins
    run_vec("invclamp", 32'd101, 32'd0, 32'h40000000, 5'd1, -8'sd5, 8'sd10, -8'sd10, 8'hF6, 1'b0);
    // negative rounding shift: (-150+2)>>>2 = -37, +3 = -34
    run_vec("negrnd", -32'sd300, 32'd0, 32'h40000000, 5'd2, 8'sd3, -8'sd128, 8'sd127, 8'hDE, 1'b0);

    // back-pressure: output parked for 10 cycles while inputs churn
    out_ready = 1'b0;
    run_vec("stall", 32'd101, 32'd0, 32'h40000000, 5'd1, -8'sd5, -8'sd128, 8'sd127, 8'd21, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      scramble();
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_data", {24'h0, out_data}, 32'd21);
      chk("stall_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", {31'b0, out_valid}, 32'd0);
    chk("release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("release_single", {31'b0, out_valid}, 32'd0);
    run_vec("after_stall", 32'h7FFFFFF0, 32'h100, 32'h7FFFFFFF, 5'd0, 8'd0, -8'sd128, 8'sd127, 8'd127, 1'b0);

    // reset while the word sits in sMUL
    @(negedge clk);
    in_acc = 32'd101; bias = 32'd0; mult = 32'h40000000; shift = 5'd1;
    out_zp = -8'sd5; act_min = -8'sd128; act_max = 8'sd127;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_data", {24'h0, out_data}, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("midrst_rel_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midrst_dropped", {31'b0, out_valid}, 32'd0);
    end
    run_vec("after_rst", 32'd101, 32'd0, 32'h40000000, 5'd1, -8'sd5, -8'sd128, 8'sd127, 8'd21, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
